sa_ctrl_collector: RTL and testbench

- Sequencing and result stage for one systolic-array matrix multiply.
- Kicks the operand vector feeder (start pulse, shift enables), waits for the feeder's over flag, then flushes the array wavefront.
- Drains the X_R x W_C accumulator grid row by row, one row per accepted beat; each element is rounded, right-shifted and saturated to D_W.
- Sits between the attention-layer sequencer (upstream) and the output matrix buffer (downstream).

---
 rtl/sa_ctrl_collector.sv | 152 +++++++++++++++
 tb/tb_sa_ctrl_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl_collector.sv
// Sequencing and result stage for one systolic-array multiply: kicks the feeder,
// flushes the array wavefront, then drains the quantised accumulator grid row by row.
module sa_ctrl_collector #(
  parameter int D_W       = 8,
  parameter int ACC_W     = 24,
  parameter int X_R       = 16,
  parameter int W_C       = 16,
  parameter int FLUSH_CYC = X_R + W_C - 2
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST_N,
  input  logic                                  I_START,
  input  logic [7:0]                            I_M_DIM,
  input  logic [4:0]                            I_QSHIFT,
  input  logic                                  I_SHIFT_EN,
  input  logic                                  I_OVER,
  input  logic [0:X_R-1][0:W_C-1][ACC_W-1:0]    I_ACC,
  output logic                                  O_MGR_START,
  output logic                                  O_PE_CLEAR,
  output logic                                  O_PE_SHIFT,
  output logic [0:W_C-1][D_W-1:0]               O_ROW_DATA,
  output logic [7:0]                            O_ROW_IDX,
  output logic                                  O_ROW_VALID,
  input  logic                                  I_ROW_READY,
  output logic                                  O_BUSY,
  output logic                                  O_DONE
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int RW = (X_R > 1) ? $clog2(X_R) : 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(X_R - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [FW-1:0] flush_cnt_r;
  logic [RW-1:0] row_r;
  logic [4:0]    qshift_r;
  logic [7:0]    m_dim_r;
  logic          mgr_start_r;
  logic          busy_r;
  logic          valid_r;
  logic          done_r;
  logic          unused_cfg_s;

  // Round half-up, arithmetic shift and saturate; one guard bit keeps the rounding add exact.
  function automatic logic [D_W-1:0] quantise(input logic [ACC_W-1:0] acc, input logic [4:0] sh);
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] t;
    wide = $signed({acc[ACC_W-1], acc});
    if (sh != 5'd0) begin
      half = $signed({{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1));
    end else begin
      half = '0;
    end
    t = (wide + half) >>> sh;
    if (t > SAT_MAX) begin
      return SAT_MAX[D_W-1:0];
    end else if (t < SAT_MIN) begin
      return SAT_MIN[D_W-1:0];
    end else begin
      return t[D_W-1:0];
    end
  endfunction

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (I_START) state_s = ST_LOAD;
        else         state_s = ST_IDLE;
      end
      ST_LOAD: state_s = ST_FEED;
      ST_FEED: begin
        if (I_OVER) state_s = ST_FLUSH;
        else        state_s = ST_FEED;
      end
      ST_FLUSH: begin
        if (I_SHIFT_EN && (flush_cnt_r == FLUSH_LAST)) state_s = ST_DRAIN;
        else                                           state_s = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (I_ROW_READY && (row_r == ROW_LAST)) state_s = ST_DONE;
        else                                    state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters, latched configuration and registered control outputs
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
      row_r       <= '0;
      qshift_r    <= 5'd0;
      m_dim_r     <= 8'd0;
      mgr_start_r <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mgr_start_r <= (state_s == ST_LOAD);
      busy_r      <= (state_s != ST_IDLE);
      valid_r     <= (state_s == ST_DRAIN);
      done_r      <= (state_s == ST_DONE);
      if ((state_r == ST_IDLE) && I_START) begin
        m_dim_r  <= I_M_DIM;
        qshift_r <= I_QSHIFT;
      end
      if ((state_r == ST_FLUSH) && I_SHIFT_EN) begin
        flush_cnt_r <= (flush_cnt_r == FLUSH_LAST) ? '0 : flush_cnt_r + 1'b1;
      end
      if ((state_r == ST_DRAIN) && I_ROW_READY) begin
        row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
      end
    end
  end

  // Row mux and quantiser; the array is frozen during drain so no extra pipeline is needed
  always_comb begin
    for (int j = 0; j < W_C; j++) begin
      if (valid_r) O_ROW_DATA[j] = quantise(I_ACC[row_r][j], qshift_r);
      else         O_ROW_DATA[j] = '0;
    end
  end

  // Sequencing follows I_OVER; the latched inner dimension is kept for debug visibility only.
  assign unused_cfg_s = ^m_dim_r;

  assign O_MGR_START = mgr_start_r;
  assign O_PE_CLEAR  = mgr_start_r;
  assign O_PE_SHIFT  = ((state_r == ST_FEED) || (state_r == ST_FLUSH)) && I_SHIFT_EN;
  assign O_ROW_IDX   = 8'(row_r);
  assign O_ROW_VALID = valid_r;
  assign O_BUSY      = busy_r;
  assign O_DONE      = done_r;

endmodule

// File: tb/tb_sa_ctrl_collector.sv
// Directed bench for sa_ctrl_collector: a quantiser vector table plus
// hand-written sequences for flow, flush stall, backpressure, busy start and reset.
module tb_sa_ctrl_collector;
  localparam int D_W = 8, ACC_W = 24, X_R = 16, W_C = 16;

  logic clk = 1'b0;
  logic rst_n, start, shift_en, over, row_ready;
  logic [7:0] m_dim;
  logic [4:0] qshift;
  logic [0:X_R-1][0:W_C-1][ACC_W-1:0] acc;
  logic mgr_start, pe_clear, pe_shift, row_valid, busy, done;
  logic [0:W_C-1][D_W-1:0] row_data;
  logic [7:0] row_idx;

  int checks = 0;
  int errors = 0;

  int n_start, n_clear, n_startclr, n_shift, n_flush_shift, n_bad_shift, n_busy_gap;
  int n_beats, n_done, n_stall, first_valid, last_accept, done_rel, busy_after, timed_out;
  logic [7:0] first_byte;

  typedef struct {
    logic [4:0]  qs;
    logic [23:0] a;
    logic [7:0]  q;
  } qvec_t;
  qvec_t qtab[14];

  always #5 clk = ~clk;

  sa_ctrl_collector dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_M_DIM(m_dim), .I_QSHIFT(qshift),
    .I_SHIFT_EN(shift_en), .I_OVER(over), .I_ACC(acc), .O_MGR_START(mgr_start),
    .O_PE_CLEAR(pe_clear), .O_PE_SHIFT(pe_shift), .O_ROW_DATA(row_data), .O_ROW_IDX(row_idx),
    .O_ROW_VALID(row_valid), .I_ROW_READY(row_ready), .O_BUSY(busy), .O_DONE(done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mgr_start"}, int'(mgr_start), 0);
    check({tag, "_pe_clear"}, int'(pe_clear), 0);
    check({tag, "_pe_shift"}, int'(pe_shift), 0);
    check({tag, "_row_valid"}, int'(row_valid), 0);
    check({tag, "_row_idx"}, int'(row_idx), 0);
    check({tag, "_row_data_nz"}, int'(row_data != '0), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < X_R; r++)
      for (int j = 0; j < W_C; j++)
        acc[r][j] = 24'((r * 16 + j) << 4);
  endtask

  // Entered at drive phase (#1 after posedge); leaves at sample phase (#2 after posedge).
  task automatic run_op(input logic [4:0] qs, input int over_dly, input bit toggle, input int stall_idx,
                        input bit busy_starts, input bit chk_data, input int abort_idx);
    int rel, exp_idx, bad, v, e;
    bit started, done_seen;
    rel = 0; exp_idx = 0; started = 0; done_seen = 0;
    n_start = 0; n_clear = 0; n_startclr = 0; n_shift = 0; n_flush_shift = 0; n_bad_shift = 0;
    n_busy_gap = 0; n_beats = 0; n_done = 0; n_stall = 0; first_valid = -1; last_accept = -1;
    done_rel = -1; busy_after = -1; first_byte = 8'h00; timed_out = 1;
    start = 1'b1; m_dim = 8'(over_dly - 2); qshift = qs;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        if (!started && mgr_start) begin
          started = 1; rel = 0;
        end else if (started) begin
          rel++;
        end
        start = busy_starts && started && (rel == 3 || (row_valid && row_idx == 8'd3));
      end
      shift_en = (toggle && started) ? rel[0] : 1'b1;
      over = started && (rel == over_dly);
      if (row_valid && int'(row_idx) == stall_idx && n_stall < 3) begin
        row_ready = 1'b0; n_stall++;
      end else begin
        row_ready = 1'b1;
      end
      #1;
      if (abort_idx >= 0 && row_valid && int'(row_idx) == abort_idx) begin
        timed_out = 0; break;
      end
      if (done_seen) begin
        busy_after = int'(busy);
        if (done) n_done++;
        timed_out = 0; break;
      end
      if (mgr_start) n_start++;
      if (pe_clear) n_clear++;
      if (mgr_start != pe_clear) n_startclr++;
      if (pe_shift) begin
        n_shift++;
        if (started && rel > over_dly && first_valid < 0) n_flush_shift++;
        if (!shift_en || row_valid || mgr_start || !busy) n_bad_shift++;
      end
      if (started && !done_seen && !busy) n_busy_gap++;
      if (row_valid) begin
        if (first_valid < 0) begin
          first_valid = rel; first_byte = row_data[0];
        end
        check("row_idx", int'(row_idx), exp_idx);
        if (chk_data) begin
          bad = 0;
          for (int j = 0; j < W_C; j++) begin
            v = exp_idx * 16 + j;
            e = (v > 127) ? 127 : v;
            if (row_data[j] != 8'(e)) bad++;
          end
          check("row_data_bad_elems", bad, 0);
        end
        if (row_ready) begin
          n_beats++; last_accept = rel; exp_idx++;
        end
      end
      if (done) begin
        n_done++; done_rel = rel; done_seen = 1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; over = 1'b0; shift_en = 1'b1; row_ready = 1'b1;
    check("op_timeout", timed_out, 0);
  endtask

  initial begin
    qtab[0]  = '{5'd4,  24'h000018, 8'h02};
    qtab[1]  = '{5'd4,  24'hFFFFE8, 8'hFF};
    qtab[2]  = '{5'd4,  24'h000800, 8'h7F};
    qtab[3]  = '{5'd4,  24'hFFF000, 8'h80};
    qtab[4]  = '{5'd0,  24'h000064, 8'h64};
    qtab[5]  = '{5'd0,  24'hFFFF80, 8'h80};
    qtab[6]  = '{5'd0,  24'h000080, 8'h7F};
    qtab[7]  = '{5'd1,  24'h000003, 8'h02};
    qtab[8]  = '{5'd1,  24'hFFFFFD, 8'hFF};
    qtab[9]  = '{5'd1,  24'h7FFFFF, 8'h7F};
    qtab[10] = '{5'd23, 24'h7FFFFF, 8'h01};
    qtab[11] = '{5'd23, 24'h800000, 8'hFF};
    qtab[12] = '{5'd8,  24'hFF8080, 8'h81};
    qtab[13] = '{5'd8,  24'hFF807F, 8'h80};

    rst_n = 1'b0; start = 1'b0; m_dim = 8'd0; qshift = 5'd0;
    shift_en = 1'b1; over = 1'b0; row_ready = 1'b1; acc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Quantiser table, each run with M_DIM=0 (I_OVER two cycles after the start pulse)
    for (int i = 0; i < 14; i++) begin
      acc = '0;
      acc[0][0] = qtab[i].a;
      run_op(qtab[i].qs, 2, 1'b0, -1, 1'b0, 1'b0, -1);
      check($sformatf("quant_%0d", i), int'(first_byte), int'(qtab[i].q));
      check($sformatf("quant_latency_%0d", i), first_valid, 33);
      @(posedge clk); #1;
    end

    // Basic flow, M_DIM=4
    fill_pattern();
    run_op(5'd4, 6, 1'b0, -1, 1'b0, 1'b1, -1);
    check("basic_start_cycles", n_start, 1);
    check("basic_clear_cycles", n_clear, 1);
    check("basic_start_clear_skew", n_startclr, 0);
    check("basic_shift_total", n_shift, 36);
    check("basic_flush_shifts", n_flush_shift, 30);
    check("basic_bad_shift", n_bad_shift, 0);
    check("basic_first_valid", first_valid, 37);
    check("basic_beats", n_beats, 16);
    check("basic_done_count", n_done, 1);
    check("basic_done_after_last", done_rel, last_accept + 1);
    check("basic_busy_after_done", busy_after, 0);
    check("basic_busy_gap", n_busy_gap, 0);
    @(posedge clk); #1;

    // Flush stall: SHIFT_EN alternates
    run_op(5'd4, 6, 1'b1, -1, 1'b0, 1'b1, -1);
    check("stall_flush_shifts", n_flush_shift, 30);
    check("stall_shift_total", n_shift, 33);
    check("stall_bad_shift", n_bad_shift, 0);
    check("stall_first_valid", first_valid, 66);
    check("stall_beats", n_beats, 16);
    @(posedge clk); #1;

    // Backpressure on row 5
    run_op(5'd4, 6, 1'b0, 5, 1'b0, 1'b1, -1);
    check("bp_stall_cycles", n_stall, 3);
    check("bp_beats", n_beats, 16);
    check("bp_drain_span", last_accept - first_valid, 18);
    check("bp_done_count", n_done, 1);
    @(posedge clk); #1;

    // START pulses in FEED and DRAIN
    run_op(5'd4, 6, 1'b0, -1, 1'b1, 1'b1, -1);
    check("busy_start_cycles", n_start, 1);
    check("busy_clear_cycles", n_clear, 1);
    check("busy_done_count", n_done, 1);
    check("busy_beats", n_beats, 16);
    @(posedge clk); #1;

    // Async reset while row 7 is presented
    run_op(5'd4, 6, 1'b0, -1, 1'b0, 1'b1, 7);
    check("abort_rows_before_reset", n_beats, 7);
    #3;
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", int'(busy), 0);
    run_op(5'd4, 6, 1'b0, -1, 1'b0, 1'b1, -1);
    check("rerun_first_valid", first_valid, 37);
    check("rerun_beats", n_beats, 16);
    check("rerun_done_count", n_done, 1);
    check("rerun_busy_after_done", busy_after, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
